// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returns the
// gain-scaled magnitude and the binary angle of an (x, y) vector.
module cordic_vector_iter #(
  parameter int unsigned BW_SHIFT_VALUE = 4,
  parameter int unsigned N_FRAC         = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [N_FRAC+1:0]        mag_o,
  output logic signed [N_FRAC:0]   angle_o
);

  localparam int unsigned XW = N_FRAC + 3;
  localparam int unsigned ZW = N_FRAC + 1;
  localparam int unsigned MW = N_FRAC + 2;
  localparam int unsigned CW = BW_SHIFT_VALUE;

  localparam logic [ZW-1:0] Z_PI = {1'b1, N_FRAC'(0)};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic signed [XW-1:0]  y_q, y_d;
  logic [ZW-1:0]         z_q, z_d;
  logic [MW-1:0]         mag_q, mag_d;
  logic [ZW-1:0]         angle_q, angle_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;

  logic                  last_iter;
  logic signed [XW-1:0]  x_shift, y_shift;
  logic [ZW-1:0]         z_step;

  // atan(2^-i) in units of pi/2^N_FRAC; table is exact for N_FRAC=15 and scaled otherwise
  function automatic logic [ZW-1:0] atan_lut(input logic [CW-1:0] i);
    int     idx;
    longint base;
    idx = int'(i);
    case (idx)
      0:       base = 8192;
      1:       base = 4836;
      2:       base = 2555;
      3:       base = 1297;
      4:       base = 651;
      5:       base = 326;
      6:       base = 163;
      7:       base = 81;
      8:       base = 41;
      9:       base = 20;
      10:      base = 10;
      11:      base = 5;
      12:      base = 3;
      13:      base = 1;
      14:      base = 1;
      default: base = 0;
    endcase
    return ZW'((base <<< N_FRAC) >>> 15);
  endfunction

  assign last_iter = (cnt_q == {CW{1'b1}});
  assign x_shift   = x_q >>> cnt_q;
  assign y_shift   = y_q >>> cnt_q;
  assign z_step    = atan_lut(cnt_q);

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_i) state_d = S_ITER;
      S_ITER:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    angle_d = angle_q;
    valid_d = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          cnt_d = '0;
          // Left half-plane vectors are rotated by pi so the micro-rotations converge
          if (x_i[N_FRAC]) begin
            x_d = -XW'(x_i);
            y_d = -XW'(y_i);
            z_d = Z_PI;
          end else begin
            x_d = XW'(x_i);
            y_d = XW'(y_i);
            z_d = '0;
          end
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (!y_q[XW-1]) begin
          x_d = x_q + y_shift;
          y_d = y_q - x_shift;
          z_d = z_q + z_step;
        end else begin
          x_d = x_q - y_shift;
          y_d = y_q + x_shift;
          z_d = z_q - z_step;
        end
        if (last_iter) begin
          mag_d   = x_d[MW-1:0];
          angle_d = z_d;
        end
      end
      default: ;
    endcase
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign mag_o   = mag_q;
  assign angle_o = angle_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench for cordic_vector_iter: directed vectors with tolerance
// bounds plus random vectors against an integer CORDIC reference.
module tb_cordic_vector_iter;

  logic               clk_i;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [15:0] x_i;
  logic signed [15:0] y_i;
  logic               valid_o;
  logic               ready_i;
  logic [16:0]        mag_o;
  logic signed [15:0] angle_o;

  int n_cmp = 0;
  int n_bad = 0;

  int atan_tab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                       41, 20, 10, 5, 3, 1, 1, 0};

  cordic_vector_iter #(.BW_SHIFT_VALUE(4), .N_FRAC(15)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .x_i     (x_i),
    .y_i     (y_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mag_o   (mag_o),
    .angle_o (angle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp, input int tol,
                       input bit wrap16);
    int d;
    n_cmp++;
    d = got - exp;
    if (wrap16) d = int'($signed(16'(d)));
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Plain integer vectoring CORDIC: pi pre-rotation, 16 micro-rotations, angle mod 2^16
  function automatic void model(input int xi, input int yi, output int mag, output int ang);
    int x, y, z, xs, ys;
    if (xi < 0) begin x = -xi; y = -yi; z = -32768; end
    else        begin x = xi;  y = yi;  z = 0;      end
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin x = x + ys; y = y - xs; z = z + atan_tab[i]; end
      else        begin x = x - ys; y = y + xs; z = z - atan_tab[i]; end
    end
    mag = x & 32'h1FFFF;
    ang = int'($signed(16'(z)));
  endfunction

  task automatic run_sample(input int xi, input int yi, output int mag, output int ang);
    int n;
    @(negedge clk_i);
    x_i = 16'(xi);
    y_i = 16'(yi);
    valid_i = 1'b1;
    check("ready_before_accept", int'(ready_o), 1, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (valid_o) break;
    end
    check("latency", n, 16, 0, 0);
    mag = int'(mag_o);
    ang = int'(angle_o);
  endtask

  task automatic consume();
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    check("valid_after_consume", int'(valid_o), 0, 0, 0);
    check("ready_after_consume", int'(ready_o), 1, 0, 0);
  endtask

  task automatic do_case(input int xi, input int yi, output int mag, output int ang);
    int em, ea;
    run_sample(xi, yi, mag, ang);
    model(xi, yi, em, ea);
    check("mag_model", mag, em, 0, 0);
    check("angle_model", ang, ea, 0, 1);
  endtask

  initial begin
    int m, a, m0, a0, seen;
    rst_i   = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b0;
    x_i     = 16'sd1234;
    y_i     = 16'sd999;

    // Reset with valid_i driven: nothing accepted
    repeat (3) @(negedge clk_i);
    check("rst_ready", int'(ready_o), 1, 0, 0);
    check("rst_valid", int'(valid_o), 0, 0, 0);
    check("rst_mag", int'(mag_o), 0, 0, 0);
    check("rst_angle", int'(angle_o), 0, 0, 0);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_ready", int'(ready_o), 1, 0, 0);
    check("idle_valid", int'(valid_o), 0, 0, 0);

    // Directed vectors
    do_case(16384, 0, m, a);
    check("x_axis_angle", a, 0, 2, 1);
    check("x_axis_mag", m, 26981, 8, 0);
    consume();
    do_case(0, 16384, m, a);
    check("pos_y_angle", a, 16384, 2, 1);
    check("pos_y_mag", m, 26981, 8, 0);
    consume();
    do_case(0, -16384, m, a);
    check("neg_y_angle", a, -16384, 2, 1);
    consume();
    do_case(-16384, 0, m, a);
    check("neg_x_angle", a, -32768, 2, 1);
    consume();
    do_case(-32768, -32768, m, a);
    check("corner_angle", a, -24576, 2, 1);
    check("corner_mag", m, 76315, 12, 0);
    consume();

    // Backpressure in DONE with valid_i toggling
    do_case(16384, 8000, m0, a0);
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      x_i = 16'($urandom);
      y_i = 16'($urandom);
      @(posedge clk_i);
      @(negedge clk_i);
      check("bp_mag", int'(mag_o), m0, 0, 0);
      check("bp_angle", int'(angle_o), a0, 0, 1);
      check("bp_ready", int'(ready_o), 0, 0, 0);
      check("bp_valid", int'(valid_o), 1, 0, 0);
    end
    valid_i = 1'b0;
    consume();
    @(negedge clk_i);
    check("no_extra_accept", int'(ready_o), 1, 0, 0);
    check("mag_kept_idle", int'(mag_o), m0, 0, 0);

    // Reset during iteration 7
    @(negedge clk_i);
    x_i = 16'sd20000;
    y_i = -16'sd5000;
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("abort_mag", int'(mag_o), 0, 0, 0);
    check("abort_angle", int'(angle_o), 0, 0, 0);
    check("abort_valid", int'(valid_o), 0, 0, 0);
    check("abort_ready", int'(ready_o), 1, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("abort_no_result", seen, 0, 0, 0);
    do_case(16384, 16384, m, a);
    check("diag_angle", a, 8192, 2, 1);
    check("diag_mag", m, 38156, 10, 0);
    consume();

    // Random vectors with random downstream stall
    for (int t = 0; t < 30; t++) begin
      int xr, yr, st;
      xr = int'($signed(16'($urandom)));
      yr = int'($signed(16'($urandom)));
      do_case(xr, yr, m, a);
      st = int'($urandom_range(0, 3));
      repeat (st) @(negedge clk_i);
      check("rand_hold_mag", int'(mag_o), m, 0, 0);
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_vector_iter.md
CORDIC_VECTOR_ITER -- requirements
Module: cordic_vector_iter

Interface
REQ-001 SHALL have parameter BW_SHIFT_VALUE, default 4: width of the iteration counter / shift amount.
REQ-002 SHALL have parameter N_FRAC, default 15: fractional bits; data inputs are N_FRAC+1 bits wide.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  input sample valid.
REQ-006 SHALL have port ready_o  output  1  block can accept a sample.
REQ-007 SHALL have port x_i  input  N_FRAC+1  signed vector x component.
REQ-008 SHALL have port y_i  input  N_FRAC+1  signed vector y component.
REQ-009 SHALL have port valid_o  output  1  result valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port mag_o  output  N_FRAC+2  unsigned magnitude, including the CORDIC gain K≈1.64676 (not compensated).
REQ-012 SHALL have port angle_o  output  N_FRAC+1  signed binary angle; -2^N_FRAC represents ±pi, 2^(N_FRAC-1) represents pi/2.

Function
REQ-013 SHALL implement an iterative vectoring-mode CORDIC: drive y to zero, accumulate atan(y/x) in z, one micro-rotation per clock.
REQ-014 SHALL use an FSM with states IDLE, ITER, DONE; ready_o=1 only in IDLE; valid_o=1 only in DONE.
REQ-015 Accept: SHALL accept a sample on an edge where valid_i=1 and ready_o=1, then go IDLE->ITER with counter=0.
REQ-016 Internal x and y SHALL be signed N_FRAC+3 bits, sign-extended from the inputs; z SHALL be N_FRAC+1 bits with modulo-2^(N_FRAC+1) wrap.
REQ-017 Pre-rotation on accept: if x_i<0, SHALL load x=-x_i, y=-y_i, z=-2^N_FRAC; otherwise SHALL load x=x_i, y=y_i, z=0.
REQ-018 Iteration i (i=counter, 0..2^BW_SHIFT_VALUE-1), y>=0: SHALL compute x+=y>>>i, y-=x>>>i, z+=A[i], using pre-update x and y on both right-hand sides.
REQ-019 Iteration i, y<0: SHALL compute x-=y>>>i, y+=x>>>i, z-=A[i].
REQ-020 A[i] for N_FRAC=15 SHALL be: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0 (round(atan(2^-i)*2^15/pi)).
REQ-021 On the edge that performs iteration 15, the FSM SHALL move ITER->DONE, so valid_o rises exactly 16 clock edges after the accepting edge.
REQ-022 In DONE, mag_o SHALL equal x[N_FRAC+1:0] and angle_o SHALL equal z.
REQ-023 mag_o and angle_o SHALL be held stable while valid_o=1 and ready_i=0 (backpressure, unbounded).
REQ-024 On an edge where valid_o=1 and ready_i=1, the FSM SHALL go DONE->IDLE; ready_o SHALL rise the next cycle, with no same-cycle re-accept.
REQ-025 valid_i SHALL be ignored in ITER and DONE; no queuing.
REQ-026 mag_o and angle_o SHALL keep their last values outside DONE; consumers qualify them with valid_o only.
REQ-027 Input (-2^N_FRAC, y) SHALL be handled without overflow through the widened internal x.

Reset
REQ-028 rst_i=0 SHALL immediately force state IDLE, counter 0, internal x/y/z 0, mag_o=0, angle_o=0, valid_o=0, ready_o=1.
REQ-029 Reset asserted mid-ITER or in DONE SHALL abort the operation with no result emitted; the first accept after release SHALL behave as from power-up.

Verification
REQ-030 Reset, then idle: ready_o=1, valid_o=0, mag_o=0, angle_o=0; drive valid_i during reset -> no accept.
REQ-031 x=16384, y=0 -> valid_o exactly 16 edges after accept; angle_o=0±2; mag_o=26981±8.
REQ-032 x=0, y=16384 -> angle_o=16384±2, mag_o=26981±8; x=0, y=-16384 -> angle_o=-16384±2.
REQ-033 x=-16384, y=0 -> angle_o within ±2 LSB of -32768, modulo 2^16 (both ±pi encodings accepted); x=-32768, y=-32768 -> angle_o=-24576±2, mag_o=76315±12.
REQ-034 Hold ready_i=0 for 5 cycles in DONE while pulsing valid_i -> outputs constant, ready_o=0, no extra accept; release -> IDLE, ready_o=1 next cycle.
REQ-035 Assert rst_i=0 at iteration 7 -> outputs zero immediately, no valid_o; next sample (x=16384, y=16384) -> angle_o=8192±2, mag_o=38156±10.
